// File: rtl/mant_div_iter.sv
// rtl/mant_div_iter.sv - iterative restoring mantissa divider, one quotient bit per cycle
module mant_div_iter (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [47:0] q_mant,
   output logic [7:0]  q_exp,
   output logic        q_sign,
   output logic        div_by_zero
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]  r_state;
   logic [25:0] r_rem;        // partial remainder, stays below 2*mb
   logic [23:0] r_mb;         // divisor mantissa with implicit 1
   logic [23:0] r_quo;        // quotient bits resolved so far
   logic [4:0]  r_cnt;        // index of the bit resolved on the next edge
   logic        r_dz_pend;
   logic        r_sign_pend;
   logic [7:0]  r_exp_pend;

   logic        w_ge;
   logic [25:0] w_diff;
   logic [25:0] w_rem_next;
   logic [24:0] w_q_next;
   logic        w_b_zero;
   logic [7:0]  w_exp_calc;

   // One restoring step: compare, conditionally subtract, shift left
   always_comb begin
      w_ge       = (r_rem >= {2'b00, r_mb});
      w_diff     = w_ge ? (r_rem - {2'b00, r_mb}) : r_rem;
      w_rem_next = w_diff << 1;
      w_q_next   = {r_quo, w_ge};
      w_b_zero   = (b[30:0] == 31'd0);
      // +23 undoes the leading-zero shift applied by the downstream normaliser
      w_exp_calc = a[30:23] - b[30:23] + 8'd150;
   end

   assign busy = (r_state == S_RUN);
   assign done = (r_state == S_DONE);

   // Control FSM, datapath iteration and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_rem       <= '0;
         r_mb        <= '0;
         r_quo       <= '0;
         r_cnt       <= '0;
         r_dz_pend   <= 1'b0;
         r_sign_pend <= 1'b0;
         r_exp_pend  <= '0;
         q_mant      <= '0;
         q_exp       <= '0;
         q_sign      <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               // DONE accepts a new start too, giving a 26-cycle back-to-back period
               if (start) begin
                  r_rem       <= {2'b01, a[22:0]};
                  r_mb        <= {1'b1, b[22:0]};
                  r_quo       <= '0;
                  r_cnt       <= 5'd24;
                  r_dz_pend   <= w_b_zero;
                  r_sign_pend <= a[31] ^ b[31];
                  r_exp_pend  <= w_exp_calc;
                  r_state     <= S_RUN;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_RUN: begin
               if (r_dz_pend) begin
                  // Zero divisor: spend a single RUN cycle, no iterations
                  q_mant      <= 48'hFFFF_FFFF_FFFF;
                  q_exp       <= 8'hFF;
                  q_sign      <= r_sign_pend;
                  div_by_zero <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_rem <= w_rem_next;
                  r_quo <= w_q_next[23:0];
                  if (r_cnt == 5'd0) begin
                     q_mant      <= {23'd0, w_q_next};
                     q_exp       <= r_exp_pend;
                     q_sign      <= r_sign_pend;
                     div_by_zero <= 1'b0;
                     r_state     <= S_DONE;
                  end else begin
                     r_cnt <= r_cnt - 5'd1;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mant_div_iter.sv
// tb/tb_mant_div_iter.sv - self-checking bench for mant_div_iter
module tb_mant_div_iter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy;
   logic        done;
   logic [47:0] q_mant;
   logic [7:0]  q_exp;
   logic        q_sign;
   logic        div_by_zero;

   int checks = 0;
   int errors = 0;

   mant_div_iter dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .q_mant(q_mant), .q_exp(q_exp),
      .q_sign(q_sign), .div_by_zero(div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: exact integer division of the significands
   function automatic logic [47:0] ref_mant(input logic [31:0] x, input logic [31:0] y);
      logic [63:0] ma, mb;
      if (y[30:0] == 31'd0) return 48'hFFFF_FFFF_FFFF;
      ma = 64'(x[22:0]) + 64'h80_0000;
      mb = 64'(y[22:0]) + 64'h80_0000;
      return 48'((ma * 64'd16777216) / mb);
   endfunction

   function automatic logic [7:0] ref_exp(input logic [31:0] x, input logic [31:0] y);
      int e;
      if (y[30:0] == 31'd0) return 8'hFF;
      e = int'(x[30:23]) - int'(y[30:23]) + 150;
      return 8'(e & 255);
   endfunction

   // Issue one operation, return the edge index at which done is seen (-1 on timeout)
   task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_in, output int lat);
      @(negedge clk);
      a = ta; b = tb_in; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a = $urandom; b = $urandom;   // post-capture changes must not matter
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         if (done) begin lat = k; break; end
         @(posedge clk);
         @(negedge clk);
         if (done) begin lat = k; break; end
      end
   endtask

   task automatic check_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_in);
      int lat;
      logic dz;
      dz = (tb_in[30:0] == 31'd0);
      run_op(ta, tb_in, lat);
      chk({tag, "_lat"}, 64'(lat), dz ? 64'd1 : 64'd25);
      chk({tag, "_mant"}, 64'(q_mant), 64'(ref_mant(ta, tb_in)));
      chk({tag, "_exp"}, 64'(q_exp), 64'(ref_exp(ta, tb_in)));
      chk({tag, "_sign"}, 64'(q_sign), 64'(ta[31] ^ tb_in[31]));
      chk({tag, "_dz"}, 64'(div_by_zero), 64'(dz));
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      @(negedge clk);
      chk({tag, "_pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      int nd, d1, d2, lat;
      logic [47:0] m1;
      logic [7:0]  e1;
      logic [31:0] ra, rb;

      // Reset state
      #12;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_mant", 64'(q_mant), 64'd0);
      chk("rst_exp", 64'(q_exp), 64'd0);
      chk("rst_dz", 64'(div_by_zero), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Known vectors
      check_op("v2div1", 32'h4000_0000, 32'h3F80_0000);
      chk("v2div1_const", 64'(q_mant), 64'h0000_0100_0000);
      chk("v2div1_econst", 64'(q_exp), 64'h97);
      check_op("v1div3", 32'h3F80_0000, 32'h4040_0000);
      chk("v1div3_const", 64'(q_mant), 64'h0000_00AA_AAAA);
      chk("v1div3_econst", 64'(q_exp), 64'h95);
      check_op("vneg", 32'hC000_0000, 32'h3F80_0000);
      chk("vneg_sign", 64'(q_sign), 64'd1);
      check_op("vdz", 32'h4000_0000, 32'h0000_0000);
      check_op("vdzneg", 32'h1234_5678, 32'h8000_0000);
      check_op("vclr", 32'h3F80_0000, 32'h3F80_0000);
      check_op("vwrap", 32'h0000_0000, 32'h7FFF_FFFF);
      check_op("vmax", 32'h7FFF_FFFF, 32'h0080_0000);

      // Randomised operations
      for (int i = 0; i < 20; i++) begin
         ra = $urandom;
         rb = $urandom;
         if (i % 7 == 3) rb[30:0] = 31'd0;
         check_op("rand", ra, rb);
      end

      // start held for 40 edges: dones at E25 and E51, inputs changed at E5
      @(negedge clk);
      a = 32'h3F80_0000; b = 32'h4040_0000; start = 1'b1;
      @(posedge clk);
      nd = 0; d1 = -1; d2 = -1; m1 = '0; e1 = '0;
      for (int k = 1; k <= 60; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            nd++;
            if (d1 < 0) begin d1 = k; m1 = q_mant; e1 = q_exp; end
            else d2 = k;
         end
         if (k == 5) begin a = 32'h4120_0000; b = 32'hC0E0_0000; end
         if (k == 39) start = 1'b0;
      end
      chk("b2b_count", 64'(nd), 64'd2);
      chk("b2b_first", 64'(d1), 64'd25);
      chk("b2b_second", 64'(d2), 64'd51);
      chk("b2b_m1", 64'(m1), 64'(ref_mant(32'h3F80_0000, 32'h4040_0000)));
      chk("b2b_e1", 64'(e1), 64'(ref_exp(32'h3F80_0000, 32'h4040_0000)));
      chk("b2b_m2", 64'(q_mant), 64'(ref_mant(32'h4120_0000, 32'hC0E0_0000)));
      chk("b2b_s2", 64'(q_sign), 64'd1);

      // Results held through a new run, then asynchronous abort at E10
      @(negedge clk);
      a = 32'h4000_0000; b = 32'h3F80_0000; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k < 10; k++) @(posedge clk);
      @(negedge clk);
      chk("hold_mant", 64'(q_mant), 64'(ref_mant(32'h4120_0000, 32'hC0E0_0000)));
      chk("hold_busy", 64'(busy), 64'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_mant", 64'(q_mant), 64'd0);
      chk("abort_exp", 64'(q_exp), 64'd0);
      chk("abort_sign", 64'(q_sign), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      nd = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("abort_nodone", 64'(nd), 64'd0);

      // First start after reset release is accepted
      check_op("post_rst", 32'h3F80_0000, 32'h4040_0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
